// File: rtl/wbuf_sched_pkg.sv
// wbuf_sched_pkg: shared drain-FSM state encoding and FIFO entry field layout
// for the write-buffer scheduler (wbuf_sched, wbuf_drain_fsm).
package wbuf_sched_pkg;

   // Drain FSM encoding; values are fixed so waveforms/debug tools agree.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_POP  = 2'd2
   } drain_state_e;

   // FIFO entry layout: {addr, data}, data in the low bits.
   localparam int unsigned ENTRY_DATA_LSB = 0;

   // Address field starts right above the data field.
   function automatic int unsigned entry_addr_lsb(input int unsigned w_data);
      return w_data;
   endfunction

endpackage

// File: rtl/wbuf_sched_if.sv
// wbuf_sched_if: store/load/snoop, compare-FIFO and memory-write signals of
// the write-buffer scheduler. slave = scheduler side, master = environment.
interface wbuf_sched_if #(
   parameter int unsigned W_ADDR        = 32,
   parameter int unsigned W_DATA        = 32,
   parameter int unsigned C_NUMBERWORDS = 4
) ();

   localparam int unsigned W_ENTRY = W_ADDR + W_DATA;

   // CPU store request
   logic                     St_valid_i;
   logic [W_ADDR-1:0]        St_addr_i;
   logic [W_DATA-1:0]        St_data_i;
   logic                     St_ready_o;

   // Load and snoop address checks
   logic                     Ld_valid_i;
   logic [W_ADDR-1:0]        Ld_addr_i;
   logic                     Ld_hit_o;
   logic                     Snp_valid_i;
   logic [W_ADDR-1:0]        Snp_addr_i;
   logic                     Snp_hit_o;

   // Attached compare-FIFO
   logic                     Fifo_write_o;
   logic                     Fifo_read_o;
   logic [W_ENTRY-1:0]       Fifo_wdata_o;
   logic [W_ENTRY-1:0]       Fifo_rdata_i;
   logic                     Fifo_empty_i;
   logic                     Fifo_full_i;
   logic [W_ADDR-1:0]        Fifo_cmp_o;
   logic [W_ADDR-1:0]        Fifo_cmp2_o;
   logic                     Fifo_cmp_en_o;
   logic                     Fifo_cmp2_en_o;
   logic [C_NUMBERWORDS-1:0] Fifo_cmp_res_i;
   logic [C_NUMBERWORDS-1:0] Fifo_cmp2_res_i;

   // Memory write handshake
   logic                     Mem_req_o;
   logic [W_ADDR-1:0]        Mem_addr_o;
   logic [W_DATA-1:0]        Mem_data_o;
   logic                     Mem_ack_i;

   modport slave (
      input  St_valid_i, St_addr_i, St_data_i,
      output St_ready_o,
      input  Ld_valid_i, Ld_addr_i,
      output Ld_hit_o,
      input  Snp_valid_i, Snp_addr_i,
      output Snp_hit_o,
      output Fifo_write_o, Fifo_read_o, Fifo_wdata_o,
      input  Fifo_rdata_i, Fifo_empty_i, Fifo_full_i,
      output Fifo_cmp_o, Fifo_cmp2_o, Fifo_cmp_en_o, Fifo_cmp2_en_o,
      input  Fifo_cmp_res_i, Fifo_cmp2_res_i,
      output Mem_req_o, Mem_addr_o, Mem_data_o,
      input  Mem_ack_i
   );

   modport master (
      output St_valid_i, St_addr_i, St_data_i,
      input  St_ready_o,
      output Ld_valid_i, Ld_addr_i,
      input  Ld_hit_o,
      output Snp_valid_i, Snp_addr_i,
      input  Snp_hit_o,
      input  Fifo_write_o, Fifo_read_o, Fifo_wdata_o,
      output Fifo_rdata_i, Fifo_empty_i, Fifo_full_i,
      input  Fifo_cmp_o, Fifo_cmp2_o, Fifo_cmp_en_o, Fifo_cmp2_en_o,
      output Fifo_cmp_res_i, Fifo_cmp2_res_i,
      input  Mem_req_o, Mem_addr_o, Mem_data_o,
      output Mem_ack_i
   );

endinterface

// File: rtl/wbuf_drain_fsm.sv
// wbuf_drain_fsm: drains the FIFO head to memory. IDLE latches the head entry
// and requests; REQ holds the request until acked; POP removes the entry.
// The entry stays in the FIFO during REQ so loads/snoops still see it.
module wbuf_drain_fsm
   import wbuf_sched_pkg::*;
#(
   parameter int unsigned W_ADDR = 32,
   parameter int unsigned W_DATA = 32
) (
   input  logic                     sClk_i,
   input  logic                     sRst_i,
   input  logic                     fifo_empty_i,
   input  logic [W_ADDR+W_DATA-1:0] fifo_rdata_i,
   input  logic                     mem_ack_i,
   output logic                     mem_req_o,
   output logic [W_ADDR-1:0]        mem_addr_o,
   output logic [W_DATA-1:0]        mem_data_o,
   output logic                     fifo_read_o,
   output drain_state_e             state_o
);

   localparam int unsigned ADDR_LSB = entry_addr_lsb(W_DATA);

   drain_state_e        state_q;
   logic                req_q;
   logic                read_q;
   logic [W_ADDR-1:0]   addr_q;
   logic [W_DATA-1:0]   data_q;

   // Drain state machine with registered request/pop strobes and latched entry.
   always_ff @(posedge sClk_i) begin
      if (sRst_i) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         read_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         read_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty_i) begin
                  state_q <= ST_REQ;
                  req_q   <= 1'b1;
                  addr_q  <= fifo_rdata_i[ADDR_LSB +: W_ADDR];
                  data_q  <= fifo_rdata_i[ENTRY_DATA_LSB +: W_DATA];
               end
            end
            ST_REQ: begin
               if (mem_ack_i) begin
                  state_q <= ST_POP;
                  req_q   <= 1'b0;
                  read_q  <= 1'b1;
               end
            end
            ST_POP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req_o   = req_q;
   assign mem_addr_o  = addr_q;
   assign mem_data_o  = data_q;
   assign fifo_read_o = read_q;
   assign state_o     = state_q;

endmodule

// File: rtl/wbuf_sched.sv
// wbuf_sched: write-buffer scheduler in front of an external compare-FIFO.
// Accepts CPU stores into the FIFO, drains them to memory one at a time,
// reports load/snoop address hits and a sticky protocol-error flag.
// Optional flush (Flush_i / Flush_done_o) when WBUF_SCHED_FLUSH_EN is defined.
module wbuf_sched
   import wbuf_sched_pkg::*;
#(
   parameter int unsigned W_ADDR        = 32,
   parameter int unsigned W_DATA        = 32,
   parameter int unsigned C_NUMBERWORDS = 4
) (
   input  logic                                   sClk_i,
   input  logic                                   sRst_i,
   wbuf_sched_if.slave                            bus_if,
   output logic [$clog2(C_NUMBERWORDS+1)-1:0]     Pend_cnt_o,
`ifdef WBUF_SCHED_FLUSH_EN
   input  logic                                   Flush_i,
   output logic                                   Flush_done_o,
`endif
   output logic                                   Err_o
);

   localparam int unsigned W_CNT = $clog2(C_NUMBERWORDS + 1);

   drain_state_e        state;
   logic                push_c;
   logic                pop;
   logic                hold;
   logic [W_CNT-1:0]    pend_cnt_q, pend_cnt_d;
   logic                err_q, err_d;

   // Store acceptance: FIFO not full and no flush in progress.
   assign push_c = bus_if.St_valid_i & ~bus_if.Fifo_full_i & ~hold;

   assign bus_if.St_ready_o   = push_c;
   assign bus_if.Fifo_write_o = push_c;
   assign bus_if.Fifo_wdata_o = {bus_if.St_addr_i, bus_if.St_data_i};

   // Load and snoop hits come straight from the FIFO's parallel compare ports.
   assign bus_if.Fifo_cmp_o     = bus_if.Ld_addr_i;
   assign bus_if.Fifo_cmp_en_o  = bus_if.Ld_valid_i;
   assign bus_if.Ld_hit_o       = bus_if.Ld_valid_i & (|bus_if.Fifo_cmp_res_i);
   assign bus_if.Fifo_cmp2_o    = bus_if.Snp_addr_i;
   assign bus_if.Fifo_cmp2_en_o = bus_if.Snp_valid_i;
   assign bus_if.Snp_hit_o      = bus_if.Snp_valid_i & (|bus_if.Fifo_cmp2_res_i);

   wbuf_drain_fsm #(
      .W_ADDR (W_ADDR),
      .W_DATA (W_DATA)
   ) u_drain (
      .sClk_i       (sClk_i),
      .sRst_i       (sRst_i),
      .fifo_empty_i (bus_if.Fifo_empty_i),
      .fifo_rdata_i (bus_if.Fifo_rdata_i),
      .mem_ack_i    (bus_if.Mem_ack_i),
      .mem_req_o    (bus_if.Mem_req_o),
      .mem_addr_o   (bus_if.Mem_addr_o),
      .mem_data_o   (bus_if.Mem_data_o),
      .fifo_read_o  (pop),
      .state_o      (state)
   );

   assign bus_if.Fifo_read_o = pop;

   // Pending-store count: saturating up on push, down on pop, hold on both.
   always_comb begin
      pend_cnt_d = pend_cnt_q;
      if (push_c && !pop) begin
         if (pend_cnt_q < W_CNT'(C_NUMBERWORDS)) pend_cnt_d = pend_cnt_q + W_CNT'(1);
      end else if (pop && !push_c) begin
         if (pend_cnt_q != '0) pend_cnt_d = pend_cnt_q - W_CNT'(1);
      end
   end

   // Sticky error: ack outside REQ, or a push into a full FIFO.
   always_comb begin
      err_d = err_q;
      if (bus_if.Mem_ack_i && (state != ST_REQ)) err_d = 1'b1;
      if (push_c && bus_if.Fifo_full_i)          err_d = 1'b1;
   end

   // Counter and error registers.
   always_ff @(posedge sClk_i) begin
      if (sRst_i) begin
         pend_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         pend_cnt_q <= pend_cnt_d;
         err_q      <= err_d;
      end
   end

   assign Pend_cnt_o = pend_cnt_q;
   assign Err_o      = err_q;

`ifdef WBUF_SCHED_FLUSH_EN
   logic hold_q, hold_d;
   logic done_q, done_d;

   // Flush: hold stores until the buffer is empty and the drain is idle.
   always_comb begin
      hold_d = hold_q;
      done_d = 1'b0;
      if (hold_q && (pend_cnt_q == '0) && (state == ST_IDLE)) begin
         hold_d = 1'b0;
         done_d = 1'b1;
      end
      if (Flush_i) hold_d = 1'b1;
   end

   // Flush hold and completion pulse registers.
   always_ff @(posedge sClk_i) begin
      if (sRst_i) begin
         hold_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         done_q <= done_d;
      end
   end

   assign hold         = hold_q;
   assign Flush_done_o = done_q;
`else
   assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_wbuf_sched.sv
// tb_wbuf_sched: directed self-checking bench for wbuf_sched with a small
// behavioural compare-FIFO model. Flush sequence runs when WBUF_SCHED_FLUSH_EN is defined.
module tb_wbuf_sched;

   localparam int unsigned W_ADDR = 32;
   localparam int unsigned W_DATA = 32;
   localparam int unsigned C_NW   = 4;
   localparam int unsigned W_E    = W_ADDR + W_DATA;

   logic       sClk = 1'b0;
   logic       sRst = 1'b1;
   logic [2:0] pend_cnt;
   logic       err;
`ifdef WBUF_SCHED_FLUSH_EN
   logic       flush = 1'b0;
   logic       flush_done;
`endif

   int checks = 0;
   int errors = 0;

   always #5 sClk = ~sClk;

   wbuf_sched_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .C_NUMBERWORDS(C_NW)) bus();

   wbuf_sched #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .C_NUMBERWORDS(C_NW)) dut (
      .sClk_i       (sClk),
      .sRst_i       (sRst),
      .bus_if       (bus),
      .Pend_cnt_o   (pend_cnt),
`ifdef WBUF_SCHED_FLUSH_EN
      .Flush_i      (flush),
      .Flush_done_o (flush_done),
`endif
      .Err_o        (err)
   );

   // ---------------- compare-FIFO model ----------------
   logic [W_E-1:0] m_ent [C_NW];
   logic [W_E-1:0] m_nxt [C_NW];
   logic [2:0]     m_cnt, m_ncnt;
   logic [C_NW-1:0] m_res, m_res2;

   always_comb begin
      m_nxt  = m_ent;
      m_ncnt = m_cnt;
      if (bus.Fifo_read_o && m_ncnt != 3'd0) begin
         for (int i = 0; i < C_NW - 1; i++) m_nxt[i] = m_nxt[i+1];
         m_ncnt = m_ncnt - 3'd1;
      end
      if (bus.Fifo_write_o && m_ncnt < 3'(C_NW)) begin
         m_nxt[m_ncnt[1:0]] = bus.Fifo_wdata_o;
         m_ncnt = m_ncnt + 3'd1;
      end
   end

   always @(posedge sClk) begin
      if (sRst) m_cnt <= 3'd0;
      else begin
         m_cnt <= m_ncnt;
         m_ent <= m_nxt;
      end
   end

   always_comb begin
      for (int i = 0; i < C_NW; i++) begin
         m_res[i]  = (3'(i) < m_cnt) && bus.Fifo_cmp_en_o  && (m_ent[i][W_E-1:W_DATA] == bus.Fifo_cmp_o);
         m_res2[i] = (3'(i) < m_cnt) && bus.Fifo_cmp2_en_o && (m_ent[i][W_E-1:W_DATA] == bus.Fifo_cmp2_o);
      end
   end

   // Model or forced FIFO inputs (forced for the combinational vector table).
   logic            model_en = 1'b0;
   logic            f_empty = 1'b1, f_full = 1'b0;
   logic [C_NW-1:0] f_res = '0, f_res2 = '0;

   assign bus.Fifo_empty_i    = model_en ? (m_cnt == 3'd0) : f_empty;
   assign bus.Fifo_full_i     = model_en ? (m_cnt == 3'(C_NW)) : f_full;
   assign bus.Fifo_rdata_i    = model_en ? m_ent[0] : '0;
   assign bus.Fifo_cmp_res_i  = model_en ? m_res  : f_res;
   assign bus.Fifo_cmp2_res_i = model_en ? m_res2 : f_res2;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next();
      @(posedge sClk);
      #1;
   endtask

   task automatic mid();
      @(negedge sClk);
   endtask

   task automatic clr_inputs();
      bus.St_valid_i  = 1'b0;
      bus.St_addr_i   = '0;
      bus.St_data_i   = '0;
      bus.Ld_valid_i  = 1'b0;
      bus.Ld_addr_i   = '0;
      bus.Snp_valid_i = 1'b0;
      bus.Snp_addr_i  = '0;
      bus.Mem_ack_i   = 1'b0;
   endtask

   task automatic do_reset();
      sRst = 1'b1;
      clr_inputs();
      next();
      next();
      sRst = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.St_valid_i = 1'b1;
      bus.St_addr_i  = a;
      bus.St_data_i  = d;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        st_valid;
      logic        full;
      logic [31:0] st_addr;
      logic [31:0] st_data;
      logic        ld_valid;
      logic [31:0] ld_addr;
      logic [3:0]  res;
      logic        snp_valid;
      logic [31:0] snp_addr;
      logic [3:0]  res2;
      logic        exp_ready;
      logic        exp_ld;
      logic        exp_snp;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h1000, 32'h11, 1'b0, 32'h0,   4'b0000, 1'b0, 32'h0,   4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h1004, 32'h22, 1'b0, 32'h0,   4'b0000, 1'b0, 32'h0,   4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h0,    32'h0,  1'b1, 32'h40,  4'b0001, 1'b0, 32'h0,   4'b0000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h0,    32'h0,  1'b0, 32'h44,  4'b1111, 1'b1, 32'h80,  4'b1000, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 32'h0,    32'h0,  1'b1, 32'h48,  4'b0000, 1'b0, 32'h84,  4'b0100, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'hABC0, 32'h5A, 1'b1, 32'h4C,  4'b0100, 1'b1, 32'h88,  4'b0010, 1'b1, 1'b1, 1'b1};

      clr_inputs();

      // Reset state while reset is held
      next();
      mid();
      chk("rst_mem_req",  64'(bus.Mem_req_o),   64'd0);
      chk("rst_mem_addr", 64'(bus.Mem_addr_o),  64'd0);
      chk("rst_mem_data", 64'(bus.Mem_data_o),  64'd0);
      chk("rst_read",     64'(bus.Fifo_read_o), 64'd0);
      chk("rst_pend",     64'(pend_cnt),        64'd0);
      chk("rst_err",      64'(err),             64'd0);
      next();
      sRst = 1'b0;

      // Combinational acceptance / hit table with forced FIFO status
      for (int i = 0; i < 6; i++) begin
         bus.St_valid_i  = vecs[i].st_valid;
         bus.St_addr_i   = vecs[i].st_addr;
         bus.St_data_i   = vecs[i].st_data;
         bus.Ld_valid_i  = vecs[i].ld_valid;
         bus.Ld_addr_i   = vecs[i].ld_addr;
         bus.Snp_valid_i = vecs[i].snp_valid;
         bus.Snp_addr_i  = vecs[i].snp_addr;
         f_full = vecs[i].full;
         f_res  = vecs[i].res;
         f_res2 = vecs[i].res2;
         mid();
         chk($sformatf("v%0d_ready", i),   64'(bus.St_ready_o),     64'(vecs[i].exp_ready));
         chk($sformatf("v%0d_write", i),   64'(bus.Fifo_write_o),   64'(vecs[i].exp_ready));
         chk($sformatf("v%0d_wdata", i),   64'(bus.Fifo_wdata_o),   {vecs[i].st_addr, vecs[i].st_data});
         chk($sformatf("v%0d_ld_hit", i),  64'(bus.Ld_hit_o),       64'(vecs[i].exp_ld));
         chk($sformatf("v%0d_snp_hit", i), 64'(bus.Snp_hit_o),      64'(vecs[i].exp_snp));
         chk($sformatf("v%0d_cmp", i),     64'(bus.Fifo_cmp_o),     64'(vecs[i].ld_addr));
         chk($sformatf("v%0d_cmp_en", i),  64'(bus.Fifo_cmp_en_o),  64'(vecs[i].ld_valid));
         chk($sformatf("v%0d_cmp2", i),    64'(bus.Fifo_cmp2_o),    64'(vecs[i].snp_addr));
         chk($sformatf("v%0d_cmp2_en", i), 64'(bus.Fifo_cmp2_en_o), 64'(vecs[i].snp_valid));
         next();
      end
      f_full = 1'b0;
      f_res  = '0;
      f_res2 = '0;

      // ---- Single store latency: push c0, req c2, ack c4, pop c5, empty c6
      model_en = 1'b1;
      do_reset();
      store(32'h100, 32'hA5);                               // c0
      mid();
      chk("a_ready_c0", 64'(bus.St_ready_o), 64'd1);
      chk("a_write_c0", 64'(bus.Fifo_write_o), 64'd1);
      next(); clr_inputs();                                 // c1
      mid();
      chk("a_req_c1",  64'(bus.Mem_req_o), 64'd0);
      chk("a_pend_c1", 64'(pend_cnt), 64'd1);
      next();                                               // c2
      mid();
      chk("a_req_c2",  64'(bus.Mem_req_o), 64'd1);
      chk("a_addr_c2", 64'(bus.Mem_addr_o), 64'h100);
      chk("a_data_c2", 64'(bus.Mem_data_o), 64'hA5);
      next();                                               // c3
      mid();
      chk("a_req_c3",  64'(bus.Mem_req_o), 64'd1);
      next(); bus.Mem_ack_i = 1'b1;                         // c4
      mid();
      chk("a_req_c4",  64'(bus.Mem_req_o), 64'd1);
      chk("a_addr_c4", 64'(bus.Mem_addr_o), 64'h100);
      next(); bus.Mem_ack_i = 1'b0;                         // c5
      mid();
      chk("a_read_c5", 64'(bus.Fifo_read_o), 64'd1);
      chk("a_req_c5",  64'(bus.Mem_req_o), 64'd0);
      next();                                               // c6
      mid();
      chk("a_read_c6", 64'(bus.Fifo_read_o), 64'd0);
      chk("a_pend_c6", 64'(pend_cnt), 64'd0);
      chk("a_err",     64'(err), 64'd0);

      // ---- Fill the FIFO, 5th store stalls until one ack drains an entry
      do_reset();
      for (int i = 0; i < 4; i++) begin                     // c0..c3
         store(32'h10 + 32'(4 * i), 32'h70 + 32'(i));
         mid();
         chk($sformatf("b_ready_%0d", i), 64'(bus.St_ready_o), 64'd1);
         if (i == 2) chk("b_addr_c2", 64'(bus.Mem_addr_o), 64'h10);
         next();
      end
      store(32'h20, 32'h99);                                // c4
      mid();
      chk("b_ready_full", 64'(bus.St_ready_o), 64'd0);
      chk("b_pend_full",  64'(pend_cnt), 64'd4);
      next(); bus.Mem_ack_i = 1'b1;                         // c5
      mid();
      chk("b_ready_c5", 64'(bus.St_ready_o), 64'd0);
      next(); bus.Mem_ack_i = 1'b0;                         // c6
      mid();
      chk("b_ready_c6", 64'(bus.St_ready_o), 64'd0);
      chk("b_read_c6",  64'(bus.Fifo_read_o), 64'd1);
      next();                                               // c7
      mid();
      chk("b_ready_c7", 64'(bus.St_ready_o), 64'd1);
      chk("b_pend_c7",  64'(pend_cnt), 64'd3);
      next(); clr_inputs();                                 // c8
      mid();
      chk("b_pend_c8", 64'(pend_cnt), 64'd4);
      chk("b_req_c8",  64'(bus.Mem_req_o), 64'd1);
      chk("b_addr_c8", 64'(bus.Mem_addr_o), 64'h14);
      next(); sRst = 1'b1;                                  // c9: reset mid-REQ
      mid();
      chk("b_req_c9", 64'(bus.Mem_req_o), 64'd1);
      next(); sRst = 1'b0;                                  // c10
      mid();
      chk("b_req_rst",  64'(bus.Mem_req_o), 64'd0);
      chk("b_pend_rst", 64'(pend_cnt), 64'd0);
      chk("b_read_rst", 64'(bus.Fifo_read_o), 64'd0);
      next();                                               // c11
      mid();
      chk("b_req_c11",  64'(bus.Mem_req_o), 64'd0);
      chk("b_read_c11", 64'(bus.Fifo_read_o), 64'd0);

      // ---- Load hits, push during POP, ack-in-IDLE error
      do_reset();
      store(32'h200, 32'h1);                                // c0
      next(); clr_inputs();                                 // c1
      bus.Ld_valid_i = 1'b1; bus.Ld_addr_i = 32'h200;
      bus.Snp_valid_i = 1'b1; bus.Snp_addr_i = 32'h200;
      mid();
      chk("c_ld_hit_c1",  64'(bus.Ld_hit_o), 64'd1);
      chk("c_snp_hit_c1", 64'(bus.Snp_hit_o), 64'd1);
      next();                                               // c2: in REQ
      mid();
      chk("c_req_c2",    64'(bus.Mem_req_o), 64'd1);
      chk("c_ld_hit_c2", 64'(bus.Ld_hit_o), 64'd1);
      next(); bus.Ld_addr_i = 32'h204; bus.Mem_ack_i = 1'b1; // c3
      bus.Snp_valid_i = 1'b0;
      mid();
      chk("c_ld_miss_c3", 64'(bus.Ld_hit_o), 64'd0);
      next(); bus.Mem_ack_i = 1'b0; bus.Ld_addr_i = 32'h200; // c4: POP
      store(32'h300, 32'h3);
      mid();
      chk("c_read_c4",  64'(bus.Fifo_read_o), 64'd1);
      chk("c_write_c4", 64'(bus.Fifo_write_o), 64'd1);
      chk("c_pend_c4",  64'(pend_cnt), 64'd1);
      chk("c_ld_hit_c4", 64'(bus.Ld_hit_o), 64'd1);
      next(); bus.St_valid_i = 1'b0;                        // c5
      bus.Snp_valid_i = 1'b1; bus.Snp_addr_i = 32'h300;
      mid();
      chk("c_pend_c5",    64'(pend_cnt), 64'd1);
      chk("c_ld_gone_c5", 64'(bus.Ld_hit_o), 64'd0);
      chk("c_snp_hit_c5", 64'(bus.Snp_hit_o), 64'd1);
      next(); clr_inputs(); bus.Mem_ack_i = 1'b1;           // c6: REQ for 0x300
      mid();
      chk("c_addr_c6", 64'(bus.Mem_addr_o), 64'h300);
      next(); bus.Mem_ack_i = 1'b0;                         // c7: POP
      next();                                               // c8: IDLE
      bus.Mem_ack_i = 1'b1;
      mid();
      chk("c_pend_c8", 64'(pend_cnt), 64'd0);
      chk("c_err_c8",  64'(err), 64'd0);
      next(); bus.Mem_ack_i = 1'b0;                         // c9
      mid();
      chk("c_err_c9", 64'(err), 64'd1);
      next();                                               // c10
      mid();
      chk("c_err_sticky", 64'(err), 64'd1);
      chk("c_req_idle",   64'(bus.Mem_req_o), 64'd0);

`ifdef WBUF_SCHED_FLUSH_EN
      // ---- Flush with two pending stores
      do_reset();
      store(32'h400, 32'h4);                                // c0
      next(); store(32'h404, 32'h5);                        // c1
      next(); clr_inputs(); flush = 1'b1;                   // c2
      next(); flush = 1'b0; store(32'h408, 32'h6);          // c3
      bus.Mem_ack_i = 1'b1;
      mid();
      chk("f_blocked_c3", 64'(bus.St_ready_o), 64'd0);
      next(); bus.Mem_ack_i = 1'b0;                         // c4 POP
      next();                                               // c5 IDLE
      mid();
      chk("f_done_c5", 64'(flush_done), 64'd0);
      next(); bus.Mem_ack_i = 1'b1;                         // c6 REQ
      next(); bus.Mem_ack_i = 1'b0;                         // c7 POP
      mid();
      chk("f_read_c7", 64'(bus.Fifo_read_o), 64'd1);
      next();                                               // c8
      mid();
      chk("f_blocked_c8", 64'(bus.St_ready_o), 64'd0);
      chk("f_done_c8",    64'(flush_done), 64'd0);
      next();                                               // c9
      mid();
      chk("f_done_c9",  64'(flush_done), 64'd1);
      chk("f_ready_c9", 64'(bus.St_ready_o), 64'd1);
      next(); clr_inputs();                                 // c10
      mid();
      chk("f_done_c10", 64'(flush_done), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Runaway guard
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
